btb_update_ctrl: RTL

Sequencer for the write side of the 2-way, 8-set branch target buffer. It buffers resolved-branch updates from execute and runs the read-check-write on the tag/valid arrays. It picks the victim way from the per-set LRU bit and drives the LRU next-state logic's update port. It also owns the invalidate sweep after reset and on a flush request.

---
 rtl/btb_pkg.sv | 33 +++
 rtl/btb_upd_fifo.sv | 74 +++++++
 rtl/btb_update_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared types and helpers for the BTB write-side sequencer.
// Index is pc[4:2], tag is pc[31:5].
package btb_pkg;

    localparam int SET_BITS = 3;
    localparam int TAG_W    = 27;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } btb_upd_t;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        WRITE,
        FLUSH
    } btb_state_e;

    function automatic logic [SET_BITS-1:0] btb_index(
        input logic [31:0] pc
    );
        return pc[SET_BITS+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(
        input logic [31:0] pc
    );
        return pc[31:32-TAG_W];
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// btb_upd_fifo: small update buffer between execute and the BTB sequencer.
// Depth must be a power of two; clr empties it in one cycle.
module btb_upd_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     clr,
    input  logic     push,
    input  btb_upd_t din,
    input  logic     pop,
    output btb_upd_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);

    btb_upd_t      mem_q [DEPTH];
    btb_upd_t      mem_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d;
    logic [PW-1:0] rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rp_q];
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    // Pointer/count update; clear wins over push and pop.
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wp_q] = din;
            wp_d        = wp_q + 1'b1;
        end
        if (do_pop) begin
            rp_d = rp_q + 1'b1;
        end
        cnt_d = cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
    end

    // Storage holds no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: read-check-write sequencer and invalidate sweep for the BTB.
// Define BTB_NT_EVICT_EN to invalidate the hit way on not-taken updates.
module btb_update_ctrl #(
    parameter int SETS       = 8,
    parameter int TAG_W      = 27,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upd_valid,
    output logic                     upd_ready,
    input  logic [31:0]              upd_pc,
    input  logic [31:0]              upd_target,
    input  logic                     upd_taken,
    input  logic                     flush_req,
    output logic                     flush_busy,
    output logic [$clog2(SETS)-1:0]  rd_set,
    input  logic                     rd_v0,
    input  logic                     rd_v1,
    input  logic [TAG_W-1:0]         rd_tag0,
    input  logic [TAG_W-1:0]         rd_tag1,
    input  logic                     lru_bit,
    output logic                     wr_en,
    output logic [$clog2(SETS)-1:0]  wr_set,
    output logic                     wr_way,
    output logic                     wr_all,
    output logic                     wr_valid,
    output logic [TAG_W-1:0]         wr_tag,
    output logic [31:0]              wr_target,
    output logic                     lru_update,
    output logic [$clog2(SETS)-1:0]  lru_index,
    output logic                     lru_wbit
);

    import btb_pkg::*;

    localparam int            SB   = $clog2(SETS);
    localparam logic [SB-1:0] LAST = SB'(SETS - 1);

    btb_state_e    state_q, state_d;
    logic [SB-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;

    btb_upd_t      upd_in;
    btb_upd_t      head;
    logic          full, empty;
    logic          push, pop, clr;
    logic [SB-1:0] head_idx;
    logic [TAG_W-1:0] head_tag;
    logic          hit0, hit1, hit;
    logic          hit_way, victim;
    logic          flush_now;

    assign upd_in    = '{pc: upd_pc, target: upd_target, taken: upd_taken};
    assign upd_ready = !rst & !full & (state_q != FLUSH);
    assign push      = upd_valid & upd_ready;
    assign pop       = !rst & (state_q == WRITE);
    assign clr       = (state_d == FLUSH);
    assign flush_now = pend_q | flush_req;

    assign head_idx = btb_index(head.pc);
    assign head_tag = btb_tag(head.pc);

    assign hit0    = rd_v0 & (rd_tag0 == head_tag);
    assign hit1    = rd_v1 & (rd_tag1 == head_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = !hit0;
    assign victim  = !rd_v0 ? 1'b0 : (!rd_v1 ? 1'b1 : lru_bit);

    btb_upd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (push),
        .din   (upd_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Next state, sweep counter and flush-pending flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_now) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (!empty || push) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = WRITE;
            WRITE: begin
                state_d = flush_now ? FLUSH : IDLE;
                cnt_d   = '0;
            end
            FLUSH: begin
                if (flush_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        pend_d = (state_d == FLUSH) ? 1'b0 : flush_now;
    end

    // Output decode from registered state, FIFO head and array read data.
    always_comb begin
        rd_set     = '0;
        wr_en      = 1'b0;
        wr_set     = '0;
        wr_way     = 1'b0;
        wr_all     = 1'b0;
        wr_valid   = 1'b0;
        wr_tag     = '0;
        wr_target  = '0;
        lru_update = 1'b0;
        lru_index  = '0;
        lru_wbit   = 1'b0;
        flush_busy = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: ;
                LOOKUP: rd_set = head_idx;
                WRITE: begin
                    wr_set    = head_idx;
                    wr_tag    = head_tag;
                    wr_target = head.target;
                    lru_index = head_idx;
                    if (head.taken) begin
                        wr_en      = 1'b1;
                        wr_valid   = 1'b1;
                        wr_way     = hit ? hit_way : victim;
                        lru_update = 1'b1;
                        lru_wbit   = ~wr_way;
                    end
`ifdef BTB_NT_EVICT_EN
                    else if (hit) begin
                        wr_en      = 1'b1;
                        wr_way     = hit_way;
                        lru_update = 1'b1;
                        lru_wbit   = hit_way;
                    end
`endif
                end
                FLUSH: begin
                    flush_busy = 1'b1;
                    wr_en      = 1'b1;
                    wr_all     = 1'b1;
                    wr_set     = cnt_q;
                    lru_update = 1'b1;
                    lru_index  = cnt_q;
                end
                default: ;
            endcase
        end
    end

    // State registers; reset lands in the sweep at set 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

endmodule
